bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16: maximum BUSY cycles without bus_ready (only used under REQ-030).
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports m0_req/m1_req, input, 1 each: transfer request, m0 = CPU, m1 = DMA.
REQ-007 SHALL have ports m0_we/m1_we, input, 1 each: 1 = write, 0 = read.
REQ-008 SHALL have ports m0_addr/m1_addr, input, ADDR_W each: byte address.
REQ-009 SHALL have ports m0_wdata/m1_wdata, input, DATA_W each: write data.
REQ-010 SHALL have ports m0_rdata/m1_rdata, output, DATA_W each: registered read data.
REQ-011 SHALL have ports m0_done/m1_done, output, 1 each: one-cycle completion pulse.
REQ-012 SHALL have ports m0_err/m1_err, output, 1 each: one-cycle error pulse, coincident with done.
REQ-013 SHALL have ports bus_read/bus_write, output, 1 each: strobes to the address decoder.
REQ-014 SHALL have ports bus_addr/bus_wdata, output, ADDR_W/DATA_W: registered address and write data.
REQ-015 SHALL have port bus_rdata, input, DATA_W: muxed slave read data.
REQ-016 SHALL have port bus_ready, input, 1: slave completes the access in this cycle.

Function
REQ-017 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-018 In IDLE with any req high: select winner, latch its we/addr/wdata into bus registers, go BUSY next edge. With no req: stay IDLE.
REQ-019 Arbitration: single requester wins. When both request, the master not granted last wins (round-robin). last_grant updates on entry to BUSY.
REQ-020 In BUSY: exactly one of bus_read/bus_write high per latched we. bus_addr/bus_wdata held stable. All strobes low in IDLE/DONE.
REQ-021 In BUSY with bus_ready=1: capture bus_rdata into winner's rdata register (reads only; writes leave rdata unchanged), go DONE.
REQ-022 In DONE: winner's done high for exactly that cycle. Other master's done stays 0. Requests ignored. Go IDLE.
REQ-023 Latency: req sampled at edge N and bus_ready=1 on first BUSY cycle -> strobe in cycle N+1, done in cycle N+2. Each extra wait cycle adds one.
REQ-024 Masters SHALL hold req/we/addr/wdata until done. Req dropped mid-transaction does not abort the transfer.
REQ-025 Req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-026 bus_ready outside BUSY SHALL be ignored.

Reset
REQ-027 On reset: state=IDLE, all strobes/done/err=0, bus_addr/bus_wdata/m0_rdata/m1_rdata=0, last_grant=m1 so m0 wins the first tie.
REQ-028 Reset asserted mid-BUSY SHALL abandon the transfer immediately with no done pulse.

Configuration
REQ-029 Macro BUS_ARB_TIMEOUT_EN SHALL select the timeout feature.
REQ-030 Defined: a cycle counter clears on BUSY entry. If TIMEOUT_CYC BUSY cycles elapse without bus_ready, go DONE with winner's done=1, err=1, rdata=0. bus_ready on the final allowed cycle completes normally.
REQ-031 Undefined: BUSY waits indefinitely, no counter is synthesized, m0_err/m1_err tied 0.

Structure
REQ-032 Package bus_pkg SHALL hold: state enum, master-id typedef (M0/M1), default ADDR_W/DATA_W/TIMEOUT_CYC constants.
REQ-033 Sub-module rr_arb2 SHALL hold the combinational 2-way round-robin pick (inputs: reqs, last_grant; output: winner). The pointer register lives in bus_arbiter.

Verification
REQ-034 m0 read addr 0x1000_0010, bus_rdata=0xDEADBEEF, bus_ready on first BUSY cycle -> bus_read for 1 cycle, m0_done 2 cycles after req, m0_rdata=0xDEADBEEF.
REQ-035 m0 and m1 request together from reset -> m0 served first, then m1. Repeated ties alternate m1, m0.
REQ-036 m1 write addr 0xC000_00A8, wdata 0x5, bus_ready after 3 wait cycles -> bus_write held 4 cycles, addr/wdata stable, m1_done once, m1_rdata unchanged.
REQ-037 Reset pulsed on 2nd BUSY cycle -> strobes drop asynchronously, no done, FSM IDLE, next tie goes to m0.
REQ-038 With BUS_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, bus_ready never high -> after 16 BUSY cycles: done=1, err=1, rdata=0. Without the macro -> still BUSY at cycle 100.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and default sizing for the two-master bus arbiter.
//   state_t  : arbiter FSM states (IDLE -> BUSY -> DONE -> IDLE)
//   master_t : master identifier, M0 = CPU, M1 = DMA
//   DEF_*    : default parameter values used by bus_arbiter and its interface
package bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 16;

endpackage

// File: rtl/bus_arbiter_if.sv
// Signal bundle between two bus masters, the arbiter and the slave-side
// address decoder.
//   m0_* / m1_* : per-master request, direction, address, write data in;
//                 registered read data, done and err pulses out
//   bus_*       : strobes, registered address/write data to the decoder;
//                 muxed read data and ready back from the slaves
// Modports:
//   slave  : the arbiter's view (serves the masters, drives the bus)
//   master : the environment's view (masters plus slave model)
interface bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req,   m1_req;
    logic              m0_we,    m1_we;
    logic [ADDR_W-1:0] m0_addr,  m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              m0_done,  m1_done;
    logic              m0_err,   m1_err;

    logic              bus_read;
    logic              bus_write;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ready;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, bus_rdata, bus_ready,
        output m0_rdata, m1_rdata, m0_done, m1_done, m0_err, m1_err,
               bus_read, bus_write, bus_addr, bus_wdata
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, bus_rdata, bus_ready,
        input  m0_rdata, m1_rdata, m0_done, m1_done, m0_err, m1_err,
               bus_read, bus_write, bus_addr, bus_wdata
    );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
//   req        : [0] = M0 request, [1] = M1 request
//   last_grant : master granted most recently (pointer kept by the caller)
//   winner     : selected master; meaningless when req == 0
module rr_arb2
    import bus_pkg::*;
(
    input  logic [1:0] req,
    input  master_t    last_grant,
    output master_t    winner
);

    always_comb begin
        winner = M0;
        if (req[0] && req[1]) begin
            // Tie: whoever did not get the previous grant goes first.
            winner = (last_grant == M0) ? M1 : M0;
        end else if (req[1]) begin
            winner = M1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (CPU = m0, DMA = m1) single-outstanding bus arbiter.
// FSM IDLE -> BUSY -> DONE -> IDLE. In IDLE the winner's we/addr/wdata are
// latched into the bus registers; BUSY drives one strobe until bus_ready;
// DONE gives the winner a one-cycle done pulse.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bif   : bus_arbiter_if.slave (master handshakes and decoder bus)
// Optional feature: define BUS_ARB_TIMEOUT_EN to bound BUSY to TIMEOUT_CYC
// cycles; on expiry the winner gets done+err and its rdata is cleared.
// Without the macro BUSY waits forever and err is tied low.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bif
);

    state_t            state_q,      state_d;
    master_t           last_grant_q, last_grant_d;
    master_t           win_q,        win_d;
    logic              we_q,         we_d;
    logic [ADDR_W-1:0] bus_addr_q,   bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q,  bus_wdata_d;
    logic [DATA_W-1:0] m0_rdata_q,   m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q,   m1_rdata_d;
    master_t           pick;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
`endif

    rr_arb2 u_rr_arb2 (
        .req        ({bif.m1_req, bif.m0_req}),
        .last_grant (last_grant_q),
        .winner     (pick)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        we_d         = we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bif.m0_req || bif.m1_req) begin
                    win_d        = pick;
                    last_grant_d = pick;
                    we_d         = (pick == M1) ? bif.m1_we    : bif.m0_we;
                    bus_addr_d   = (pick == M1) ? bif.m1_addr  : bif.m0_addr;
                    bus_wdata_d  = (pick == M1) ? bif.m1_wdata : bif.m0_wdata;
                    state_d      = S_BUSY;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            S_BUSY: begin
                if (bif.bus_ready) begin
                    // Writes leave the master's rdata register untouched.
                    if (!we_q) begin
                        if (win_q == M1) m1_rdata_d = bif.bus_rdata;
                        else             m0_rdata_d = bif.bus_rdata;
                    end
                    state_d = S_DONE;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                // cnt_q counts BUSY cycles already spent; ready on the last
                // allowed cycle is taken above and wins over the timeout.
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    if (win_q == M1) m1_rdata_d = '0;
                    else             m0_rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= M1;  // so M0 takes the first tie
            win_q        <= M0;
            we_q         <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            we_q         <= we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    // Strobes and pulses decode straight from flops, so an asynchronous
    // reset drops them immediately.
    assign bif.bus_read  = (state_q == S_BUSY) && !we_q;
    assign bif.bus_write = (state_q == S_BUSY) &&  we_q;
    assign bif.bus_addr  = bus_addr_q;
    assign bif.bus_wdata = bus_wdata_q;
    assign bif.m0_rdata  = m0_rdata_q;
    assign bif.m1_rdata  = m1_rdata_q;
    assign bif.m0_done   = (state_q == S_DONE) && (win_q == M0);
    assign bif.m1_done   = (state_q == S_DONE) && (win_q == M1);
`ifdef BUS_ARB_TIMEOUT_EN
    assign bif.m0_err    = bif.m0_done && err_q;
    assign bif.m1_err    = bif.m1_done && err_q;
`else
    assign bif.m0_err    = 1'b0;
    assign bif.m1_err    = 1'b0;
`endif

endmodule
